// File: rtl/id_pipe_fwd_pkg.sv
// Shared decode constants for the ID stage: opcodes, functs, ALU op/select codes.
package id_pipe_fwd_pkg;

  localparam logic       Enable     = 1'b1;
  localparam logic       Disable    = 1'b0;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic [4:0] NOPRegAddr = 5'b00000;

  // primary opcodes
  localparam logic [5:0] EXE_SPECIAL_INST = 6'b000000;
  localparam logic [5:0] EXE_ANDI         = 6'b001100;
  localparam logic [5:0] EXE_ORI          = 6'b001101;
  localparam logic [5:0] EXE_XORI         = 6'b001110;
  localparam logic [5:0] EXE_LUI          = 6'b001111;
  localparam logic [5:0] EXE_LW           = 6'b100011;
  localparam logic [5:0] EXE_PREF         = 6'b110011;

  // SPECIAL funct field
  localparam logic [5:0] EXE_AND  = 6'b100100;
  localparam logic [5:0] EXE_OR   = 6'b100101;
  localparam logic [5:0] EXE_XOR  = 6'b100110;
  localparam logic [5:0] EXE_NOR  = 6'b100111;
  localparam logic [5:0] EXE_SLL  = 6'b000000;
  localparam logic [5:0] EXE_SRL  = 6'b000010;
  localparam logic [5:0] EXE_SRA  = 6'b000011;
  localparam logic [5:0] EXE_SLLV = 6'b000100;
  localparam logic [5:0] EXE_SRLV = 6'b000110;
  localparam logic [5:0] EXE_SRAV = 6'b000111;
  localparam logic [5:0] EXE_SYNC = 6'b001111;

  // ALU operation codes
  localparam logic [7:0] EXE_NOP_OP  = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
  localparam logic [7:0] EXE_SLLV_OP = 8'b00000100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
  localparam logic [7:0] EXE_SRLV_OP = 8'b00000110;
  localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
  localparam logic [7:0] EXE_SRAV_OP = 8'b00000111;
  localparam logic [7:0] EXE_LW_OP   = 8'b11100011;

  // result select codes
  localparam logic [2:0] EXE_RES_NOP        = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [2:0] EXE_RES_LOAD_STORE = 3'b111;

  function automatic logic [7:0] funct_to_aluop(input logic [5:0] f);
    case (f)
      EXE_AND:  return EXE_AND_OP;
      EXE_OR:   return EXE_OR_OP;
      EXE_XOR:  return EXE_XOR_OP;
      EXE_NOR:  return EXE_NOR_OP;
      EXE_SLL:  return EXE_SLL_OP;
      EXE_SRL:  return EXE_SRL_OP;
      EXE_SRA:  return EXE_SRA_OP;
      EXE_SLLV: return EXE_SLLV_OP;
      EXE_SRLV: return EXE_SRLV_OP;
      EXE_SRAV: return EXE_SRAV_OP;
      default:  return EXE_NOP_OP;
    endcase
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// One operand's resolver: youngest matching forward source wins over the regfile,
// $0 is hard zero, and a disabled read yields the immediate.
module id_fwd_mux
  import id_pipe_fwd_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      i_re,
  input  logic [ADDR_W-1:0]         i_addr,
  input  logic [DATA_W-1:0]         i_reg_data,
  input  logic [DATA_W-1:0]         i_imm,
  input  logic [NUM_FWD-1:0]        i_fwd_we,
  input  logic [NUM_FWD*ADDR_W-1:0] i_fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] i_fwd_data,
  input  logic [NUM_FWD-1:0]        i_fwd_load,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_load_hit
);

  logic [NUM_FWD-1:0] w_match;
  logic [DATA_W-1:0]  w_src_data [NUM_FWD];

  generate
    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_src
      assign w_match[gi]    = i_fwd_we[gi] && (i_fwd_addr[gi*ADDR_W +: ADDR_W] == i_addr);
      assign w_src_data[gi] = i_fwd_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_comb begin
    o_data     = i_reg_data;
    o_load_hit = Disable;
    // walk oldest to youngest so the lowest index overrides
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (w_match[k]) begin
        o_data     = w_src_data[k];
        o_load_hit = i_fwd_load[k];
      end
    end
    if (!i_re) begin
      o_data     = i_imm;
      o_load_hit = Disable;
    end else if (i_addr == '0) begin
      o_data     = DATA_W'(ZeroWord);
      o_load_hit = Disable;
    end
  end

endmodule

// File: rtl/id_pipe_fwd.sv
// Decode stage: instruction decode, forwarded operand resolve, load-use interlock
// request and the registered ID/EX boundary with an interlock-cycle counter.
module id_pipe_fwd
  import id_pipe_fwd_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      inst_valid_i,
  input  logic [DATA_W-1:0]         pc_i,
  input  logic [31:0]               inst_i,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_we_i,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data_i,
  input  logic [NUM_FWD-1:0]        fwd_load_i,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  output logic [ADDR_W-1:0]         reg1_addr_o,
  output logic [ADDR_W-1:0]         reg2_addr_o,
  output logic                      stallreq_o,
  output logic                      ex_valid_o,
  output logic [DATA_W-1:0]         ex_pc_o,
  output logic [7:0]                ex_aluop_o,
  output logic [2:0]                ex_alusel_o,
  output logic [DATA_W-1:0]         ex_reg1_o,
  output logic [DATA_W-1:0]         ex_reg2_o,
  output logic [DATA_W-1:0]         ex_imm_o,
  output logic [ADDR_W-1:0]         ex_wd_o,
  output logic                      ex_wreg_o,
  output logic                      ex_load_o,
  output logic                      ex_invalid_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  logic [5:0]        w_op, w_funct;
  logic [4:0]        w_sa;
  logic [15:0]       w_imm16;
  logic [ADDR_W-1:0] w_rs, w_rt, w_rd;
  assign w_op    = inst_i[31:26];
  assign w_funct = inst_i[5:0];
  assign w_sa    = inst_i[10:6];
  assign w_imm16 = inst_i[15:0];
  assign w_rs    = ADDR_W'(inst_i[25:21]);
  assign w_rt    = ADDR_W'(inst_i[20:16]);
  assign w_rd    = ADDR_W'(inst_i[15:11]);

  logic              w_read1, w_read2, w_wreg, w_load, w_invalid;
  logic [7:0]        w_aluop;
  logic [2:0]        w_alusel;
  logic [ADDR_W-1:0] w_wd;
  logic [DATA_W-1:0] w_imm1, w_imm2, w_ex_imm, w_sext, w_zext;
  assign w_sext = {{(DATA_W-16){w_imm16[15]}}, w_imm16};
  assign w_zext = {{(DATA_W-16){1'b0}}, w_imm16};

  always_comb begin
    w_read1   = Disable;
    w_read2   = Disable;
    w_aluop   = EXE_NOP_OP;
    w_alusel  = EXE_RES_NOP;
    w_wd      = ADDR_W'(NOPRegAddr);
    w_wreg    = Disable;
    w_load    = Disable;
    w_invalid = Disable;
    w_imm1    = '0;
    w_imm2    = '0;
    w_ex_imm  = '0;
    if (inst_valid_i) begin
      case (w_op)
        EXE_SPECIAL_INST: begin
          case (w_funct)
            EXE_AND, EXE_OR, EXE_XOR, EXE_NOR: begin
              w_read1  = Enable;
              w_read2  = Enable;
              w_wreg   = Enable;
              w_wd     = w_rd;
              w_aluop  = funct_to_aluop(w_funct);
              w_alusel = EXE_RES_LOGIC;
            end
            EXE_SLLV, EXE_SRLV, EXE_SRAV: begin
              w_read1  = Enable;
              w_read2  = Enable;
              w_wreg   = Enable;
              w_wd     = w_rd;
              w_aluop  = funct_to_aluop(w_funct);
              w_alusel = EXE_RES_SHIFT;
            end
            EXE_SLL, EXE_SRL, EXE_SRA: begin
              // constant shifts need a zero rs field; sa travels in operand 1
              if (inst_i[25:21] == 5'd0) begin
                w_read2  = Enable;
                w_imm1   = {{(DATA_W-5){1'b0}}, w_sa};
                w_wreg   = Enable;
                w_wd     = w_rd;
                w_aluop  = funct_to_aluop(w_funct);
                w_alusel = EXE_RES_SHIFT;
              end else begin
                w_invalid = Enable;
              end
            end
            EXE_SYNC: begin
            end
            default: w_invalid = Enable;
          endcase
        end
        EXE_ORI, EXE_ANDI, EXE_XORI: begin
          w_read1  = Enable;
          w_imm2   = w_zext;
          w_wreg   = Enable;
          w_wd     = w_rt;
          w_alusel = EXE_RES_LOGIC;
          w_aluop  = (w_op == EXE_ORI)  ? EXE_OR_OP :
                     (w_op == EXE_ANDI) ? EXE_AND_OP : EXE_XOR_OP;
        end
        EXE_LUI: begin
          w_read1  = Enable;
          w_imm2   = DATA_W'({w_imm16, 16'h0000});
          w_wreg   = Enable;
          w_wd     = w_rt;
          w_aluop  = EXE_OR_OP;
          w_alusel = EXE_RES_LOGIC;
        end
        EXE_LW: begin
          w_read1  = Enable;
          w_imm2   = w_sext;
          w_ex_imm = w_sext;
          w_load   = Enable;
          w_wreg   = Enable;
          w_wd     = w_rt;
          w_aluop  = EXE_LW_OP;
          w_alusel = EXE_RES_LOAD_STORE;
        end
        EXE_PREF: begin
        end
        default: w_invalid = Enable;
      endcase
    end
  end

  logic [DATA_W-1:0] w_op1, w_op2;
  logic              w_hit1, w_hit2, w_stallreq;

  id_fwd_mux #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux1 (
    .i_re(w_read1), .i_addr(w_rs), .i_reg_data(reg1_data_i), .i_imm(w_imm1),
    .i_fwd_we(fwd_we_i), .i_fwd_addr(fwd_addr_i), .i_fwd_data(fwd_data_i),
    .i_fwd_load(fwd_load_i), .o_data(w_op1), .o_load_hit(w_hit1)
  );

  id_fwd_mux #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux2 (
    .i_re(w_read2), .i_addr(w_rt), .i_reg_data(reg2_data_i), .i_imm(w_imm2),
    .i_fwd_we(fwd_we_i), .i_fwd_addr(fwd_addr_i), .i_fwd_data(fwd_data_i),
    .i_fwd_load(fwd_load_i), .o_data(w_op2), .o_load_hit(w_hit2)
  );

  assign w_stallreq  = inst_valid_i && !flush_i && (w_hit1 || w_hit2);
  assign stallreq_o  = w_stallreq;
  assign reg1_read_o = w_read1;
  assign reg2_read_o = w_read2;
  assign reg1_addr_o = w_rs;
  assign reg2_addr_o = w_rt;

  logic              r_valid, r_wreg, r_load, r_invalid;
  logic [DATA_W-1:0] r_pc, r_reg1, r_reg2, r_imm;
  logic [7:0]        r_aluop;
  logic [2:0]        r_alusel;
  logic [ADDR_W-1:0] r_wd;
  logic [CNT_W-1:0]  r_stall_cnt;

  // a bubble is all-zero; the downstream stall only holds when no flush is present
  always_ff @(posedge clk) begin
    if (rst == Enable || flush_i || (!stall_i && w_stallreq)) begin
      r_valid   <= Disable;
      r_pc      <= '0;
      r_aluop   <= EXE_NOP_OP;
      r_alusel  <= EXE_RES_NOP;
      r_reg1    <= '0;
      r_reg2    <= '0;
      r_imm     <= '0;
      r_wd      <= ADDR_W'(NOPRegAddr);
      r_wreg    <= Disable;
      r_load    <= Disable;
      r_invalid <= Disable;
    end else if (!stall_i) begin
      r_valid   <= inst_valid_i;
      r_pc      <= inst_valid_i ? pc_i : '0;
      r_aluop   <= w_aluop;
      r_alusel  <= w_alusel;
      r_reg1    <= w_op1;
      r_reg2    <= w_op2;
      r_imm     <= w_ex_imm;
      r_wd      <= w_wd;
      r_wreg    <= w_wreg;
      r_load    <= w_load;
      r_invalid <= w_invalid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == Enable) begin
      r_stall_cnt <= '0;
    end else if (w_stallreq && !stall_i && !flush_i && r_stall_cnt != {CNT_W{1'b1}}) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign ex_valid_o   = r_valid;
  assign ex_pc_o      = r_pc;
  assign ex_aluop_o   = r_aluop;
  assign ex_alusel_o  = r_alusel;
  assign ex_reg1_o    = r_reg1;
  assign ex_reg2_o    = r_reg2;
  assign ex_imm_o     = r_imm;
  assign ex_wd_o      = r_wd;
  assign ex_wreg_o    = r_wreg;
  assign ex_load_o    = r_load;
  assign ex_invalid_o = r_invalid;
  assign stall_cnt_o  = r_stall_cnt;

endmodule

// File: tb/tb_id_pipe_fwd.sv
// Directed bench for id_pipe_fwd: instruction-level reference model checked every cycle,
// plus hand-computed expectations at each scenario.
module tb_id_pipe_fwd;

  logic        clk = 1'b0;
  logic        rst, stall_i, flush_i, inst_valid_i;
  logic [31:0] pc_i, inst_i, reg1_data_i, reg2_data_i;
  logic [1:0]  fwd_we_i, fwd_load_i;
  logic [9:0]  fwd_addr_i;
  logic [63:0] fwd_data_i;
  logic        reg1_read_o, reg2_read_o, stallreq_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o, ex_wd_o;
  logic        ex_valid_o, ex_wreg_o, ex_load_o, ex_invalid_o;
  logic [31:0] ex_pc_o, ex_reg1_o, ex_reg2_o, ex_imm_o;
  logic [7:0]  ex_aluop_o;
  logic [2:0]  ex_alusel_o;
  logic [3:0]  stall_cnt_o;

  always #5 clk = ~clk;

  id_pipe_fwd #(.DATA_W(32), .ADDR_W(5), .NUM_FWD(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .inst_valid_i(inst_valid_i), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_we_i(fwd_we_i), .fwd_addr_i(fwd_addr_i), .fwd_data_i(fwd_data_i),
    .fwd_load_i(fwd_load_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .stallreq_o(stallreq_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
    .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o),
    .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o), .ex_imm_o(ex_imm_o),
    .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o), .ex_load_o(ex_load_o),
    .ex_invalid_o(ex_invalid_o), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1, r2, imm;
    logic [4:0]  wd;
    logic        wreg, load, invalid;
  } ex_t;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // operand source: disabled read -> immediate, $0 -> 0, else first matching source from index 0
  function automatic logic [31:0] mres(input logic en, input logic [4:0] a,
                                       input logic [31:0] rf, input logic [31:0] imm,
                                       output logic ld);
    ld = 1'b0;
    if (!en) return imm;
    if (a == 5'd0) return 32'h0;
    for (int k = 0; k < 2; k++) begin
      if (fwd_we_i[k] && fwd_addr_i[k*5 +: 5] == a) begin
        ld = fwd_load_i[k];
        return fwd_data_i[k*32 +: 32];
      end
    end
    return rf;
  endfunction

  function automatic ex_t mdec(output logic rd1, output logic rd2, output logic sreq);
    ex_t e;
    logic en1, en2, l1, l2;
    logic [31:0] i1, i2;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic [15:0] im;
    e = '0; en1 = 0; en2 = 0; i1 = 0; i2 = 0;
    op = inst_i[31:26]; fn = inst_i[5:0]; im = inst_i[15:0];
    rs = inst_i[25:21]; rt = inst_i[20:16]; rd = inst_i[15:11];
    if (inst_valid_i) begin
      e.valid = 1'b1;
      e.pc = pc_i;
      case (op)
        6'h00: case (fn)
          6'h24, 6'h25, 6'h26, 6'h27: begin
            en1 = 1; en2 = 1; e.aluop = {2'b00, fn}; e.alusel = 3'd1; e.wreg = 1; e.wd = rd;
          end
          6'h04, 6'h06, 6'h07: begin
            en1 = 1; en2 = 1; e.aluop = {2'b00, fn}; e.alusel = 3'd2; e.wreg = 1; e.wd = rd;
          end
          6'h00, 6'h02, 6'h03: begin
            if (rs == 5'd0) begin
              en2 = 1; i1 = {27'd0, inst_i[10:6]};
              e.aluop = (fn == 6'h00) ? 8'h7C : {2'b00, fn};
              e.alusel = 3'd2; e.wreg = 1; e.wd = rd;
            end else e.invalid = 1;
          end
          6'h0F: ;
          default: e.invalid = 1;
        endcase
        6'h0C, 6'h0D, 6'h0E: begin
          en1 = 1; i2 = {16'h0, im}; e.alusel = 3'd1; e.wreg = 1; e.wd = rt;
          e.aluop = (op == 6'h0C) ? 8'h24 : (op == 6'h0D) ? 8'h25 : 8'h26;
        end
        6'h0F: begin
          en1 = 1; i2 = {im, 16'h0}; e.aluop = 8'h25; e.alusel = 3'd1; e.wreg = 1; e.wd = rt;
        end
        6'h23: begin
          en1 = 1; i2 = {{16{im[15]}}, im}; e.imm = i2; e.load = 1;
          e.aluop = 8'hE3; e.alusel = 3'd7; e.wreg = 1; e.wd = rt;
        end
        6'h33: ;
        default: e.invalid = 1;
      endcase
    end
    e.r1 = mres(en1, rs, reg1_data_i, i1, l1);
    e.r2 = mres(en2, rt, reg2_data_i, i2, l2);
    rd1 = en1; rd2 = en2;
    sreq = inst_valid_i && !flush_i && (l1 || l2);
    return e;
  endfunction

  ex_t        m_ex;
  logic [3:0] m_cnt;
  logic       m_ok = 1'b0;

  always @(posedge clk) begin
    ex_t d;
    logic a, b, s;
    d = mdec(a, b, s);
    if (rst) begin
      m_ex = '0; m_cnt = 4'd0; m_ok = 1'b1;
    end else begin
      if (flush_i) m_ex = '0;
      else if (!stall_i) m_ex = s ? '0 : d;
      if (s && !stall_i && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
    end
  end

  always @(negedge clk) begin
    ex_t d, act;
    logic a, b, s;
    if (m_ok) begin
      d = mdec(a, b, s);
      act = '{ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o,
               ex_imm_o, ex_wd_o, ex_wreg_o, ex_load_o, ex_invalid_o};
      chk("model_ex", 160'(act), 160'(m_ex));
      chk("model_cnt", 160'(stall_cnt_o), 160'(m_cnt));
      chk("model_comb", 160'({reg1_read_o, reg2_read_o, stallreq_o, reg1_addr_o, reg2_addr_o}),
          160'({a, b, s, inst_i[25:21], inst_i[20:16]}));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk(nm, 160'(act), 160'(exp));
    $display("check %s: got %0h want %0h", nm, act, exp);
  endtask

  initial begin
    rst = 1; stall_i = 0; flush_i = 0; inst_valid_i = 0; pc_i = 0; inst_i = 0;
    reg1_data_i = 0; reg2_data_i = 0; fwd_we_i = 0; fwd_addr_i = 0; fwd_data_i = 0; fwd_load_i = 0;
    step(); step();
    lit("rst_valid", 32'(ex_valid_o), 32'h0);
    lit("rst_cnt", 32'(stall_cnt_o), 32'h0);
    rst = 0;

    // ORI $1,$0,0x1234
    inst_valid_i = 1; pc_i = 32'h100; inst_i = 32'h3401_1234; reg1_data_i = 32'h9999;
    step();
    lit("ori_r1", ex_reg1_o, 32'h0);
    lit("ori_r2", ex_reg2_o, 32'h1234);
    lit("ori_wd", 32'(ex_wd_o), 32'h1);
    lit("ori_pc", ex_pc_o, 32'h100);

    // OR $2,$1,$1 with ORI result at source 0
    inst_i = 32'h0021_1025; fwd_we_i = 2'b01; fwd_addr_i = {5'd0, 5'd1}; fwd_data_i = {32'h0, 32'h1234};
    #1 lit("or_sreq", 32'(stallreq_o), 32'h0);
    step();
    lit("or_r1", ex_reg1_o, 32'h1234);
    lit("or_r2", ex_reg2_o, 32'h1234);

    fwd_we_i = 2'b11; fwd_addr_i = {5'd1, 5'd1}; fwd_data_i = {32'hBBBB, 32'hAAAA};
    step();
    lit("prio_young", ex_reg1_o, 32'hAAAA);
    fwd_we_i = 2'b10;
    step();
    lit("prio_old", ex_reg1_o, 32'hBBBB);

    // OR $2,$0,$0 with a (load) source targeting $0
    inst_i = 32'h0000_1025; fwd_we_i = 2'b01; fwd_addr_i = {5'd0, 5'd0};
    fwd_data_i = {32'h0, 32'hFFFF}; fwd_load_i = 2'b01; reg1_data_i = 32'h1111; reg2_data_i = 32'h1111;
    #1 lit("zero_sreq", 32'(stallreq_o), 32'h0);
    step();
    lit("zero_r1", ex_reg1_o, 32'h0);
    lit("zero_r2", ex_reg2_o, 32'h0);

    // AND $4,$3,$5 behind LW $3
    inst_i = 32'h0065_2024; reg2_data_i = 32'h77; fwd_we_i = 2'b01; fwd_addr_i = {5'd0, 5'd3}; fwd_load_i = 2'b01;
    #1 lit("lu_sreq", 32'(stallreq_o), 32'h1);
    step();
    lit("lu_bubble", 32'(ex_valid_o), 32'h0);
    fwd_we_i = 2'b10; fwd_addr_i = {5'd3, 5'd0}; fwd_data_i = {32'h55, 32'h0}; fwd_load_i = 2'b00;
    #1 lit("lu_sreq2", 32'(stallreq_o), 32'h0);
    step();
    lit("lu_r1", ex_reg1_o, 32'h55);
    lit("lu_r2", ex_reg2_o, 32'h77);
    lit("lu_cnt", 32'(stall_cnt_o), 32'h1);

    // load still pending at source 1: stall persists
    fwd_we_i = 2'b01; fwd_addr_i = {5'd0, 5'd3}; fwd_load_i = 2'b01;
    step();
    fwd_we_i = 2'b10; fwd_addr_i = {5'd3, 5'd0}; fwd_load_i = 2'b10;
    #1 lit("lu_persist", 32'(stallreq_o), 32'h1);
    step();
    lit("lu_persist_bub", 32'(ex_valid_o), 32'h0);
    fwd_load_i = 2'b00; fwd_data_i = {32'h66, 32'h0};
    step();
    lit("lu_persist_r1", ex_reg1_o, 32'h66);
    lit("lu_persist_cnt", 32'(stall_cnt_o), 32'h3);

    // hold beats hazard, flush beats everything
    fwd_we_i = 2'b01; fwd_addr_i = {5'd0, 5'd3}; fwd_load_i = 2'b01; stall_i = 1;
    #1 lit("hold_sreq", 32'(stallreq_o), 32'h1);
    step();
    lit("hold_r1", ex_reg1_o, 32'h66);
    lit("hold_valid", 32'(ex_valid_o), 32'h1);
    lit("hold_cnt", 32'(stall_cnt_o), 32'h3);
    stall_i = 0; flush_i = 1;
    #1 lit("flush_sreq", 32'(stallreq_o), 32'h0);
    step();
    lit("flush_valid", 32'(ex_valid_o), 32'h0);
    lit("flush_wreg", 32'(ex_wreg_o), 32'h0);
    lit("flush_cnt", 32'(stall_cnt_o), 32'h3);
    flush_i = 0; fwd_we_i = 2'b00; fwd_load_i = 2'b00;

    // SRA $2,$3,4
    inst_i = 32'h0003_1103; reg2_data_i = 32'h8000_0010;
    #1 lit("sra_rd", 32'({reg1_read_o, reg2_read_o}), 32'h1);
    step();
    lit("sra_r1", ex_reg1_o, 32'h4);
    lit("sra_r2", ex_reg2_o, 32'h8000_0010);
    lit("sra_wd", 32'(ex_wd_o), 32'h2);

    // LW $2,-4($3)
    inst_i = 32'h8C62_FFFC; reg1_data_i = 32'h1000;
    step();
    lit("lw_imm", ex_imm_o, 32'hFFFF_FFFC);
    lit("lw_load", 32'(ex_load_o), 32'h1);
    lit("lw_r1", ex_reg1_o, 32'h1000);

    inst_i = 32'h3C05_ABCD;
    step();
    lit("lui_r2", ex_reg2_o, 32'hABCD_0000);

    inst_i = 32'hFC00_0000;
    step();
    lit("rsv_invalid", 32'(ex_invalid_o), 32'h1);
    lit("rsv_wreg", 32'(ex_wreg_o), 32'h0);

    inst_i = 32'h0000_000F;
    step();
    lit("sync_flags", 32'({ex_valid_o, ex_wreg_o, ex_invalid_o}), 32'h4);

    // XORI $6,$1,0xF0 with $1 from source 1
    inst_i = 32'h3826_00F0; fwd_we_i = 2'b10; fwd_addr_i = {5'd1, 5'd0}; fwd_data_i = {32'h5, 32'h0};
    step();
    lit("xori_ops", ex_reg1_o ^ ex_reg2_o, 32'hF5);

    inst_valid_i = 0;
    step();
    lit("bubble_valid", 32'(ex_valid_o), 32'h0);

    // saturation then reset mid-stall
    rst = 1; step(); rst = 0;
    inst_valid_i = 1; inst_i = 32'h0065_2024; fwd_we_i = 2'b01; fwd_addr_i = {5'd0, 5'd3}; fwd_load_i = 2'b01;
    repeat (20) step();
    lit("sat_cnt", 32'(stall_cnt_o), 32'hF);
    rst = 1;
    step();
    lit("rst_mid_cnt", 32'(stall_cnt_o), 32'h0);
    lit("rst_mid_valid", 32'(ex_valid_o), 32'h0);
    lit("rst_mid_sreq", 32'(stallreq_o), 32'h1);
    rst = 0; fwd_we_i = 0; fwd_load_i = 0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/id_pipe_fwd.md
# id_pipe_fwd

Parametrised decode stage with registered ID/EX output, N-source operand forwarding and load-use interlock. Sits between the IF/ID register and EX. It decodes the logic/shift/immediate subset plus LW, resolves operands from the regfile or any of `NUM_FWD` younger pipeline stages, and requests a stall when an operand depends on an in-flight load. It also counts interlock cycles for performance monitoring.

## Interface
Parameters:
- `DATA_W`, 32, operand/PC width
- `ADDR_W`, 5, register address width
- `NUM_FWD`, 2, forwarding sources; index 0 is youngest (EX), ascending index is older
- `CNT_W`, 16, interlock counter width

Ports:
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  synchronous, active-high reset (`Enable` = 1'b1)
- `stall_i`  in  1  downstream stall: hold ID/EX register
- `flush_i`  in  1  kill: load a bubble into ID/EX
- `inst_valid_i`  in  1  IF/ID holds a real instruction
- `pc_i`  in  DATA_W  instruction address
- `inst_i`  in  32  instruction word
- `reg1_data_i`, `reg2_data_i`  in  DATA_W  regfile read data
- `fwd_we_i`  in  NUM_FWD  source k writes a register
- `fwd_addr_i`  in  NUM_FWD*ADDR_W  destination of source k (slice k)
- `fwd_data_i`  in  NUM_FWD*DATA_W  result of source k
- `fwd_load_i`  in  NUM_FWD  source k is a load whose data is not yet valid
- `reg1_read_o`, `reg2_read_o`  out  1  combinational regfile read enables
- `reg1_addr_o`, `reg2_addr_o`  out  ADDR_W  combinational read addresses (rs, rt)
- `stallreq_o`  out  1  combinational load-use stall request
- `ex_valid_o`  out  1  ID/EX holds a real instruction
- `ex_pc_o`  out  DATA_W  registered PC
- `ex_aluop_o`  out  8  registered ALU op
- `ex_alusel_o`  out  3  registered result select
- `ex_reg1_o`, `ex_reg2_o`  out  DATA_W  registered operands
- `ex_imm_o`  out  DATA_W  registered sign-extended offset (LW only, else 0)
- `ex_wd_o`  out  ADDR_W  registered destination
- `ex_wreg_o`  out  1  registered write enable
- `ex_load_o`  out  1  registered: instruction is LW
- `ex_invalid_o`  out  1  registered reserved-instruction flag
- `stall_cnt_o`  out  CNT_W  saturating interlock-cycle count

## Operation
- **Decode (comb).**
  - AND/OR/XOR/NOR/SLLV/SRLV/SRAV: read rs and rt, write rd.
  - SLL/SRL/SRA (`inst[31:21]`=0): read rt only; the shift amount `sa` is zero-extended into operand 1.
  - ORI/ANDI/XORI: read rs, write rt; imm is zero-extended into operand 2.
  - LUI: read rs, write rt; operand 2 = {imm,16'h0}.
  - LW: read rs, write rt; `ex_load_o`=1, ex_imm = sign-extended imm.
  - SYNC/PREF: valid NOP, no write.
  - Any other encoding: aluop NOP, wreg=0, `ex_invalid_o`=1.
  - `inst_valid_i`=0 decodes as a bubble.
- **Operand resolve, per operand.** Read enabled means operand = first matching k with `fwd_we_i[k]` && addr==`fwd_addr_i[k]`, lowest k wins; if none match, regfile data. Read disabled means operand = imm.
  - Address 0 never forwards; it returns 0 regardless of sources.
- **Load-use.** If the winning match for an enabled read has `fwd_load_i[k]`=1, then `stallreq_o`=1, gated by `inst_valid_i` and masked by `flush_i`.
- **ID/EX update priority:**
  - `rst`: all registered outputs 0, `stall_cnt_o`=0.
  - `flush_i`: bubble (valid, wreg, load, invalid = 0; aluop NOP).
  - `stall_i`: hold all.
  - `stallreq_o`: bubble. The upstream controller holds IF/ID, so the instruction re-decodes next cycle.
  - else: load the decoded values.
- **Counter.** `stall_cnt_o` increments on each cycle with `stallreq_o`=1 && !`stall_i` && !`flush_i`, and saturates at all-ones.

## Timing
- Decode, read enables/addresses and `stallreq_o` are combinational from `inst_i` and the `fwd_*` inputs in the same cycle.
- ID/EX outputs have 1-cycle latency.
- **LW followed by a dependent instruction:** exactly one bubble when LW is at source 0 and its data arrives via source 1 next cycle. If source 1 is also a pending load, the stall persists until it clears.
- **Simultaneous events:**
  - `stall_i` with a hazard: hold wins, no bubble, no count.
  - `flush_i` with anything: bubble wins.
- **Reset mid-stall:** the next cycle all registered outputs are 0, the counter is 0 and `stallreq_o` is purely combinational.

## Structure
- The shared defines package holds:
  - opcode/funct constants (incl. `EXE_LW`);
  - aluop/alusel codes (incl. `EXE_LW_OP`, `EXE_RES_LOAD_STORE`);
  - `Enable`/`Disable`, `ZeroWord`, `NOPRegAddr`.
- Sub-module `id_fwd_mux`, parametrised by `NUM_FWD`/`DATA_W`/`ADDR_W`, is instantiated once per operand. It returns the resolved data and a `load_hit` flag.

## Test plan
- **ORI then dependent OR:** ORI $1,$0,0x1234 is in source 0 (we=1, addr=1, data=0x1234) while ID holds OR $2,$1,$1 -> `ex_reg1_o`=`ex_reg2_o`=0x1234, `stallreq_o`=0.
- **Forward priority:** source 0 = {1, 0xAAAA}, source 1 = {1, 0xBBBB} -> 0xAAAA. Destination $0 with data 0xFFFF -> operand 0.
- **Load-use:**
  - Cycle 1: source 0 is LW to $3 (`fwd_load_i[0]`=1) while ID holds AND $4,$3,$5 -> `stallreq_o`=1 and a bubble the next cycle.
  - Cycle 2: source 1 data 0x55 -> AND issues with reg1=0x55.
  - Result: `stall_cnt_o`=1.
- **Priority:** stall_i=1 with a hazard -> outputs held, counter unchanged. flush_i=1 -> `ex_valid_o`=0, `ex_wreg_o`=0.
- **SRA / LW / reserved decode:** SRA $2,$3,4 -> reg1=4, reg2=rt value, wd=2. LW $2,-4($3) -> `ex_imm_o`=0xFFFFFFFC, `ex_load_o`=1. Opcode 6'b111111 -> `ex_invalid_o`=1, wreg=0.
- **Counter saturation and reset:** with CNT_W=4, run 20 hazard cycles -> 15. Assert rst mid-stall -> all outputs 0 the next cycle.
